instr_loop_sequencer: RTL

//  Upstream stage of the instruction buffer BRAM controller. Accepts host instructions and writes
//  the non-control ones into the buffer. Pads the init section with NOPs so loop bodies start at

---
 rtl/instr_loop_sequencer_pkg.sv | 12 +
 rtl/instr_loop_sequencer_loop_iter_counter.sv | 53 +++++
 rtl/instr_loop_sequencer.sv | 102 ++++++++++
 3 files changed

// File: rtl/instr_loop_sequencer_pkg.sv
// instr_loop_sequencer_pkg: shared opcodes and instruction width for the instruction buffer front end
// Contents: INSTR_W_DEF, OP_NOP / OP_LOOP / OP_END, opcode field helper.
package instr_loop_sequencer_pkg;
    localparam int INSTR_W_DEF = 32;
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LOOP = 4'hE;
    localparam logic [3:0] OP_END  = 4'hF;

    function automatic logic [3:0] opcode_of(input logic [INSTR_W_DEF-1:0] instr);
        return instr[INSTR_W_DEF-1 -: 4];
    endfunction
endpackage

// File: rtl/instr_loop_sequencer_loop_iter_counter.sv
// loop_iter_counter: loop iteration count with load, saturating decrement and end_of_loop edge detect
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   load, n             load iteration count max(n,1) and mark a loop body present
//   clr                 forget the loop (buffer being cleared)
//   run                 sequencer is executing; gates decrement and outputs
//   end_of_loop         read side at last buffered address (level, edge-detected here)
//   buffer_reset        read side finished; suppresses a coincident decrement
//   loop_en, last_loop  loop body present with >= 2 iterations left / final iteration
module loop_iter_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] n,
    input  logic             clr,
    input  logic             run,
    input  logic             end_of_loop,
    input  logic             buffer_reset,
    output logic             loop_en,
    output logic             last_loop
);
    logic [CNT_W-1:0] remaining;
    logic             has_loop;
    logic             eol_q;
    logic             dec;

    // Count iterations on the rising edge only; remaining saturates at 1.
    assign dec = run & end_of_loop & ~eol_q & ~buffer_reset & (remaining > CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
            has_loop  <= 1'b0;
            eol_q     <= 1'b0;
        end else begin
            eol_q <= end_of_loop;
            if (clr) begin
                remaining <= '0;
                has_loop  <= 1'b0;
            end else if (load) begin
                remaining <= (n == '0) ? CNT_W'(1) : n;
                has_loop  <= 1'b1;
            end else if (dec) begin
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

    assign loop_en   = run & has_loop & (remaining >= CNT_W'(2));
    assign last_loop = run & (~has_loop | (remaining == CNT_W'(1)));
endmodule

// File: rtl/instr_loop_sequencer.sv
// instr_loop_sequencer: accepts host instructions, writes them to the buffer, pads init with NOPs, drives loop status
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   app_en, app_instr, app_ack   host instruction handshake
//   wr_addr, full, last_in_init  buffer write-side status
//   end_of_loop, buffer_reset    buffer read-side status
//   buf_wr, buf_wdata            buffer write strobe and data at wr_addr
//   looping, loop_en, last_loop  execution status
//   err_ovf                      sticky overflow / late-LOOP error
//   run_cycles                   only with LOOP_STATS_EN: saturating count of looping cycles
module instr_loop_sequencer
    import instr_loop_sequencer_pkg::*;
#(
    parameter int WIDTH      = 11,
    parameter int INSTR_W    = INSTR_W_DEF,
    parameter int LOOP_START = 512,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               app_en,
    input  logic [INSTR_W-1:0] app_instr,
    output logic               app_ack,
    input  logic [WIDTH-1:0]   wr_addr,
    input  logic               full,
    input  logic               last_in_init,
    input  logic               end_of_loop,
    input  logic               buffer_reset,
    output logic               buf_wr,
    output logic [INSTR_W-1:0] buf_wdata,
    output logic               looping,
    output logic               loop_en,
    output logic               last_loop,
    output logic               err_ovf
`ifdef LOOP_STATS_EN
    ,
    output logic [31:0]        run_cycles
`endif
);
    typedef enum logic [1:0] {FILL, PAD, RUN, DRAIN} state_t;

    state_t     state, next_state;
    logic [3:0] op;
    logic       is_loop, is_end, acc, wr_plain, late_loop;

    assign op        = app_instr[INSTR_W-1 -: 4];
    assign is_loop   = op == OP_LOOP;
    assign is_end    = op == OP_END;
    assign acc       = state == FILL && app_en && !full;
    assign wr_plain  = acc & ~is_loop & ~is_end;
    assign late_loop = wr_addr > WIDTH'(LOOP_START);

    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= next_state;
    end

    // LOOP past LOOP_START cannot be in init, so it never enters PAD.
    always_comb begin
        next_state = state;
        case (state)
            FILL:    next_state = (acc && is_loop && last_in_init) ? PAD :
                                  (acc && is_end && wr_addr != '0) ? RUN : FILL;
            PAD:     next_state = last_in_init ? PAD : FILL;
            RUN:     next_state = buffer_reset ? DRAIN : RUN;
            default: next_state = buffer_reset ? DRAIN : FILL;
        endcase
    end

    always_comb begin
        app_ack   = acc;
        buf_wr    = wr_plain | (state == PAD && last_in_init);
        buf_wdata = wr_plain ? app_instr : {OP_NOP, {(INSTR_W-4){1'b0}}};
        looping   = state == RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) err_ovf <= 1'b0;
        else if ((state == FILL && app_en && full) || (acc && is_loop && late_loop)) err_ovf <= 1'b1;
    end

    loop_iter_counter #(.CNT_W(CNT_W)) u_iter (
        .clk          (clk),
        .rst          (rst),
        .load         (acc & is_loop & ~late_loop),
        .n            (app_instr[CNT_W-1:0]),
        .clr          (state == DRAIN),
        .run          (looping),
        .end_of_loop  (end_of_loop),
        .buffer_reset (buffer_reset),
        .loop_en      (loop_en),
        .last_loop    (last_loop)
    );

`ifdef LOOP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) run_cycles <= '0;
        else if (state == FILL && next_state == RUN) run_cycles <= '0;
        else if (looping && run_cycles != '1) run_cycles <= run_cycles + 32'd1;
    end
`endif
endmodule
